// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   - opcode map (OP_ADD .. OP_OR); unlisted opcodes execute as add
//   - FSM state enum (IDLE / EXEC / DONE)
//   - status flag bundle
//   - signed-overflow helpers for add/sub
// Optional feature macro used by the design files: SEQ_ALU_DIV_EN.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
        logic div0;
    } flags_t;

    // Operands of equal sign producing a result of the other sign.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // Operands of differing sign where the result sign departs from the minuend.
    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Handshake bus between the decode/register-read stage, the sequential ALU and writeback.
//   request : in_valid, in_ready, op[3:0], a, b
//   response: out_valid, out_ready, result, flag_zero, flag_carry, flag_ovf, flag_div0
// master : upstream/downstream side (drives request, accepts response)
// slave  : the ALU
interface seq_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_ovf;
    logic             flag_div0;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf, flag_div0
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf, flag_div0
    );

endinterface

// File: rtl/seq_alu_iter.sv
// Iterative datapath shared by multiply and divide.
//   clk, rst_n : clock, synchronous active-low reset
//   start_i    : load operands and begin WIDTH iterations
//   is_div_i   : (SEQ_ALU_DIV_EN only) select restoring divide instead of shift-add multiply
//   a_i, b_i   : operands, sampled on start_i
//   done_o     : the current cycle performs the last iteration
//   acc_o      : accumulator value after the current iteration
// Multiply: acc = {partial high, multiplier}; each step adds a when the LSB is set, then shifts
// right, leaving the 2*WIDTH product. Divide: acc = {remainder, dividend}; each step shifts left
// and shifts in one quotient bit, leaving the quotient in the low half.
// SEQ_ALU_DIV_EN: when undefined, the divide path is not built.
module seq_alu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
`ifdef SEQ_ALU_DIV_EN
    input  logic               is_div_i,
`endif
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] acc_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_nxt;
    // Multiplicand for mul, divisor for div.
    logic [WIDTH-1:0]   opnd_q;

    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH-1:0] mul_nxt;

    always_comb begin
        hi_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nxt = {hi_sum, acc_q[WIDTH-1:1]};
    end

`ifdef SEQ_ALU_DIV_EN
    logic               div_q;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_sub;
    logic               q_bit;
    logic [2*WIDTH-1:0] div_nxt;

    always_comb begin
        // Remainder shifted left with the next dividend bit appended.
        rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        rem_sub = rem_sh - {1'b0, opnd_q};
        // rem_sh < 2*divisor, so a non-negative difference always fits in WIDTH bits and the
        // top bit of the difference is a clean borrow indicator.
        q_bit   = ~rem_sub[WIDTH];
        div_nxt = {(q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], q_bit};
        acc_nxt = div_q ? div_nxt : mul_nxt;
    end
`else
    always_comb begin
        acc_nxt = mul_nxt;
    end
`endif

    assign done_o = busy_q && (cnt_q == LastCnt);
    assign acc_o  = acc_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q  <= is_div_i;
            opnd_q <= is_div_i ? b_i : a_i;
            acc_q  <= {{WIDTH{1'b0}}, (is_div_i ? a_i : b_i)};
`else
            opnd_q <= a_i;
            acc_q  <= {{WIDTH{1'b0}}, b_i};
`endif
        end else if (busy_q) begin
            acc_q <= acc_nxt;
            if (done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential, handshaked ALU between register-read and writeback.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : seq_alu_if.slave (request in_valid/in_ready/op/a/b,
//                response out_valid/out_ready/result/flag_*)
// add/sub/and/or (and unlisted opcodes, as add) complete on the accept edge; mul and div run
// WIDTH iterations in seq_alu_iter. Result and flags are registered on entry to DONE and held
// until out_ready. in_ready and out_valid are pure state decodes.
// SEQ_ALU_DIV_EN: when undefined, op 0011 returns result 0 with flag_div0 set in one cycle.
module seq_alu import alu_pkg::*; #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input logic       clk,
    input logic       rst_n,
    seq_alu_if.slave  bus
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    flags_t             flags_q, flags_d;

    logic               accept;
    logic               iter_start;
    logic               iter_done;
    logic [2*WIDTH-1:0] iter_acc;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;

`ifdef SEQ_ALU_DIV_EN
    logic               div_q, div_d;
    logic               is_div;
    assign is_div = (bus.op == OP_DIV);
`endif

    assign accept = bus.in_valid && (state_q == IDLE);

    assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff = {1'b0, bus.a} - {1'b0, bus.b};

    seq_alu_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (iter_start),
`ifdef SEQ_ALU_DIV_EN
        .is_div_i (is_div),
`endif
        .a_i      (bus.a),
        .b_i      (bus.b),
        .done_o   (iter_done),
        .acc_o    (iter_acc)
    );

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        flags_d    = flags_q;
        iter_start = 1'b0;
`ifdef SEQ_ALU_DIV_EN
        div_d      = div_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    flags_d = '0;
                    case (bus.op)
                        OP_MUL: begin
                            iter_start = 1'b1;
                            state_d    = EXEC;
`ifdef SEQ_ALU_DIV_EN
                            div_d      = 1'b0;
`endif
                        end
                        OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
                            if (bus.b == '0) begin
                                result_d     = '1;
                                flags_d.div0 = 1'b1;
                                state_d      = DONE;
                            end else begin
                                iter_start = 1'b1;
                                div_d      = 1'b1;
                                state_d    = EXEC;
                            end
`else
                            // No divider built: report it through div0 with a zero result.
                            result_d     = '0;
                            flags_d.div0 = 1'b1;
                            state_d      = DONE;
`endif
                        end
                        OP_SUB: begin
                            result_d      = diff[WIDTH-1:0];
                            flags_d.carry = diff[WIDTH];
                            flags_d.ovf   = sub_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1],
                                                    diff[WIDTH-1]);
                            state_d       = DONE;
                        end
                        OP_AND: begin
                            result_d = bus.a & bus.b;
                            state_d  = DONE;
                        end
                        OP_OR: begin
                            result_d = bus.a | bus.b;
                            state_d  = DONE;
                        end
                        default: begin
                            result_d      = sum[WIDTH-1:0];
                            flags_d.carry = sum[WIDTH];
                            flags_d.ovf   = add_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1],
                                                    sum[WIDTH-1]);
                            state_d       = DONE;
                        end
                    endcase
                end
            end
            EXEC: begin
                if (iter_done) begin
                    result_d = iter_acc[WIDTH-1:0];
                    flags_d  = '0;
`ifdef SEQ_ALU_DIV_EN
                    if (!div_q) begin
                        flags_d.ovf = |iter_acc[2*WIDTH-1:WIDTH];
                    end
`else
                    flags_d.ovf = |iter_acc[2*WIDTH-1:WIDTH];
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Zero flag always tracks the registered result, so it is derived once here.
        flags_d.zero = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
`ifdef SEQ_ALU_DIV_EN
            div_q    <= div_d;
`endif
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.result     = result_q;
    assign bus.flag_zero  = flags_q.zero;
    assign bus.flag_carry = flags_q.carry;
    assign bus.flag_ovf   = flags_q.ovf;
    assign bus.flag_div0  = flags_q.div0;

endmodule
